// File: rtl/pipe_pkg.sv
// Shared pipeline types: opcodes, decode control bundle and the ID/EX register layout.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic uses_rs;
        logic uses_rt;
    } ctrl_t;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RT,
        DST_RD
    } dst_sel_e;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] rd_val;
        logic [31:0] imm;
        logic [4:0]  dst;
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } idex_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: control bundle plus destination register select.
module decode_ctrl
    import pipe_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [4:0] rt_i,
    input  logic [4:0] rd_i,
    output ctrl_t      ctrl_o,
    output logic [4:0] dst_o
);

    ctrl_t    ctrl_raw;
    dst_sel_e dst_sel;

    always_comb begin
        // NOTE: defaults first so every path assigns every bit; otherwise a latch is inferred.
        ctrl_raw = '0;
        dst_sel  = DST_NONE;
        unique case (op_i)
            OP_RTYPE: begin
                ctrl_raw = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, uses_rs: 1'b1, uses_rt: 1'b1};
                dst_sel  = DST_RD;
            end
            OP_ADDI: begin
                ctrl_raw = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0, uses_rs: 1'b1, uses_rt: 1'b0};
                dst_sel  = DST_RT;
            end
            OP_LW: begin
                ctrl_raw = '{reg_write: 1'b1, mem_read: 1'b1, mem_write: 1'b0, uses_rs: 1'b1, uses_rt: 1'b0};
                dst_sel  = DST_RT;
            end
            OP_SW:   ctrl_raw = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1, uses_rs: 1'b1, uses_rt: 1'b1};
            OP_BEQ:  ctrl_raw = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0, uses_rs: 1'b1, uses_rt: 1'b1};
            default: ctrl_raw = '0;
        endcase
    end

    always_comb begin
        unique case (dst_sel)
            DST_RT:  dst_o = rt_i;
            DST_RD:  dst_o = rd_i;
            default: dst_o = 5'd0;
        endcase
        ctrl_o           = ctrl_raw;
        // r0 is hardwired zero, so a write to it is never a real write.
        ctrl_o.reg_write = ctrl_raw.reg_write & (dst_o != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register read addressing, load-use hazard detection,
// ID/EX pipeline register and a saturating stall counter.
module decode_stage
    import pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [31:0]            if_pc,
    input  logic                   flush,
    output logic                   stall_if,
    output logic [4:0]             read_reg1,
    output logic [4:0]             read_reg2,
    output logic [4:0]             read_reg3,
    input  logic [31:0]            data_out1,
    input  logic [31:0]            data_out2,
    input  logic [31:0]            data_out3,
    output logic                   idex_valid,
    output logic [5:0]             idex_op,
    output logic [31:0]            idex_rs_val,
    output logic [31:0]            idex_rt_val,
    output logic [31:0]            idex_rd_val,
    output logic [31:0]            idex_imm,
    output logic [4:0]             idex_dst,
    output logic [31:0]            idex_pc,
    output logic                   idex_reg_write,
    output logic                   idex_mem_read,
    output logic                   idex_mem_write,
    output logic [STALL_CNT_W-1:0] stall_count
);

    idex_t                  idex_q, idex_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t                  ctrl;
    logic [4:0]             dst;
    logic                   hazard;

    assign read_reg1 = if_instr[25:21];
    assign read_reg2 = if_instr[20:16];
    assign read_reg3 = if_instr[15:11];

    decode_ctrl u_decode_ctrl (
        .op_i   (if_instr[31:26]),
        .rt_i   (if_instr[20:16]),
        .rd_i   (if_instr[15:11]),
        .ctrl_o (ctrl),
        .dst_o  (dst)
    );

    assign hazard = if_valid & idex_q.valid & idex_q.mem_read & (idex_q.dst != 5'd0) &
                    ((ctrl.uses_rs & (read_reg1 == idex_q.dst)) |
                     (ctrl.uses_rt & (read_reg2 == idex_q.dst)));
    assign stall_if = hazard & ~flush;

    always_comb begin
        idex_d = idex_q;
        cnt_d  = cnt_q;
        if (flush || hazard) begin
            // Bubble: data fields are don't-care, only validity and controls are cleared.
            idex_d.valid     = 1'b0;
            idex_d.reg_write = 1'b0;
            idex_d.mem_read  = 1'b0;
            idex_d.mem_write = 1'b0;
            if (!flush && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            idex_d.valid     = if_valid;
            idex_d.op        = if_instr[31:26];
            idex_d.rs_val    = data_out1;
            idex_d.rt_val    = data_out2;
            idex_d.rd_val    = data_out3;
            idex_d.imm       = sign_ext16(if_instr[15:0]);
            idex_d.dst       = dst;
            idex_d.pc        = if_pc;
            idex_d.reg_write = ctrl.reg_write & if_valid;
            idex_d.mem_read  = ctrl.mem_read  & if_valid;
            idex_d.mem_write = ctrl.mem_write & if_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
            cnt_q  <= '0;
        end else begin
            idex_q <= idex_d;
            cnt_q  <= cnt_d;
        end
    end

    assign idex_valid     = idex_q.valid;
    assign idex_op        = idex_q.op;
    assign idex_rs_val    = idex_q.rs_val;
    assign idex_rt_val    = idex_q.rt_val;
    assign idex_rd_val    = idex_q.rd_val;
    assign idex_imm       = idex_q.imm;
    assign idex_dst       = idex_q.dst;
    assign idex_pc        = idex_q.pc;
    assign idex_reg_write = idex_q.reg_write;
    assign idex_mem_read  = idex_q.mem_read;
    assign idex_mem_write = idex_q.mem_write;
    assign stall_count    = cnt_q;

endmodule
